// File: rtl/data_mem_responder.sv
// Byte-addressable data memory that answers one load/store at a time with a
// fixed LATENCY between request acceptance and response.
module data_mem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 4096,
  parameter int LATENCY   = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_width,
  input  logic            req_sign_extend,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault
);
  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [1:0]      width_q;
  logic            write_q, sext_q, fault_q;
  logic            enter_resp;

  logic [7:0] mem [MEM_BYTES];

  // With LATENCY=1 the access completes on the accepting edge, so the live
  // request fields are used while IDLE and the captured ones afterwards.
  logic            in_idle;
  logic [XLEN-1:0] cur_addr, cur_wdata;
  logic [1:0]      cur_width;
  logic            cur_write, cur_sext;
  assign in_idle   = (state_q == IDLE);
  assign cur_addr  = in_idle ? req_addr        : addr_q;
  assign cur_wdata = in_idle ? req_wdata       : wdata_q;
  assign cur_width = in_idle ? req_width       : width_q;
  assign cur_write = in_idle ? req_write       : write_q;
  assign cur_sext  = in_idle ? req_sign_extend : sext_q;

  logic [2:0]    nbytes;
  logic          fault;
  logic [AW-1:0] idx;
  logic [7:0]    b [4];
  logic [XLEN-1:0] load_data;

  always_comb begin
    case (cur_width)
      2'd0:    nbytes = 3'd1;
      2'd1:    nbytes = 3'd2;
      2'd2:    nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
  end

  // Range test is done one bit wider so addresses near 2^XLEN cannot wrap.
  assign fault = (cur_width == 2'd3)
              || (cur_width == 2'd1 && cur_addr[0])
              || (cur_width == 2'd2 && cur_addr[1:0] != 2'b00)
              || (({1'b0, cur_addr} + (XLEN+1)'(nbytes)) > (XLEN+1)'(MEM_BYTES));

  assign idx = cur_addr[AW-1:0];

  always_comb begin
    for (int k = 0; k < 4; k++) b[k] = mem[idx + AW'(k)];
    load_data = '0;
    case (cur_width)
      2'd0: if (cur_sext) load_data = XLEN'($signed(b[0]));
            else          load_data = XLEN'(b[0]);
      2'd1: if (cur_sext) load_data = XLEN'($signed({b[1], b[0]}));
            else          load_data = XLEN'({b[1], b[0]});
      2'd2: load_data = XLEN'({b[3], b[2], b[1], b[0]});
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        if (LATENCY == 1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: if (cnt_q <= 4'd1) begin
        state_d    = RESP;
        enter_resp = 1'b1;
        cnt_d      = 4'd0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      write_q <= 1'b0;
      sext_q  <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        width_q <= req_width;
        write_q <= req_write;
        sext_q  <= req_sign_extend;
      end
      if (enter_resp) begin
        rdata_q <= (cur_write || fault) ? '0 : load_data;
        fault_q <= fault;
      end
    end
  end

  // Storage survives reset; reset_n gates the commit so an aborted store never lands.
  always_ff @(posedge clock) begin
    if (reset_n && enter_resp && cur_write && !fault) begin
      for (int k = 0; k < 4; k++)
        if (3'(k) < nbytes) mem[idx + AW'(k)] <= cur_wdata[8*k +: 8];
    end
  end

  assign req_ready  = in_idle;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus handshake,
// backpressure, reset and back-to-back sequences.
module tb_data_mem_responder;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write, req_sign_extend;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.XLEN(32), .MEM_BYTES(4096), .LATENCY(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_width(req_width), .req_sign_extend(req_sign_extend),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [1:0]  wd;
    logic        sx;
    logic [31:0] wdt;
    logic [31:0] er;
    logic        ef;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [1:0] wd,
                       input logic sx, input logic [31:0] wdt);
    req_write = w; req_addr = a; req_width = wd; req_sign_extend = sx; req_wdata = wdt;
  endtask

  // lat = negedges from the accepting edge until resp_valid is seen, which is
  // the number of rising edges until the response can be taken.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] wd,
                        input logic sx, input logic [31:0] wdt,
                        output logic [31:0] rd, output logic f, output int lat, output bit ok);
    int n;
    @(negedge clock);
    drive(w, a, wd, sx, wdt);
    req_valid = 1'b1; resp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clock); n++; end
    ok = 1'b0; rd = '0; f = 1'b0; lat = 0;
    if (!req_ready) begin req_valid = 1'b0; return; end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clock); lat++; end
    rd = resp_rdata; f = resp_fault; ok = resp_valid;
    @(posedge clock);
  endtask

  function automatic logic [31:0] mword(input logic [11:0] a);
    return {dut.mem[a + 12'd3], dut.mem[a + 12'd2], dut.mem[a + 12'd1], dut.mem[a]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd;
    logic        f;
    int          lat, g;
    bit          ok;
    logic [31:0] exp3 [3];

    reset_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    drive(1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    @(negedge clock);
    chk("reset_req_ready",  32'(req_ready),  32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_rdata",      resp_rdata,      32'h0);
    chk("reset_fault",      32'(resp_fault), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    //                w     addr          wd    sx    wdata          exp rdata     exp fault
    tbl.push_back('{1'b1, 32'h10,       2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h10,       2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0});
    tbl.push_back('{1'b1, 32'h20,       2'd2, 1'b0, 32'h11223344, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 32'h20,       2'd0, 1'b0, 32'hAAAAAA80, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h20,       2'd0, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0});
    tbl.push_back('{1'b0, 32'h20,       2'd0, 1'b0, 32'h0,        32'h00000080, 1'b0});
    tbl.push_back('{1'b0, 32'h20,       2'd2, 1'b1, 32'h0,        32'h11223380, 1'b0});
    tbl.push_back('{1'b0, 32'h23,       2'd0, 1'b1, 32'h0,        32'h00000011, 1'b0});
    tbl.push_back('{1'b1, 32'h21,       2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'h24,       2'd1, 1'b0, 32'hCAFE8001, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'h24,       2'd1, 1'b1, 32'h0,        32'hFFFF8001, 1'b0});
    tbl.push_back('{1'b0, 32'h24,       2'd1, 1'b0, 32'h0,        32'h00008001, 1'b0});
    tbl.push_back('{1'b0, 32'hFFE,      2'd2, 1'b0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'hFFE,      2'd1, 1'b0, 32'h0000BEEF, 32'h0,        1'b0});
    tbl.push_back('{1'b0, 32'hFFE,      2'd1, 1'b0, 32'h0,        32'h0000BEEF, 1'b0});
    tbl.push_back('{1'b0, 32'hFFF,      2'd0, 1'b1, 32'h0,        32'hFFFFFFBE, 1'b0});
    tbl.push_back('{1'b1, 32'h1000,     2'd2, 1'b0, 32'h55555555, 32'h0,        1'b1});
    tbl.push_back('{1'b1, 32'hFFFFFFFC, 2'd2, 1'b0, 32'h55555555, 32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'h10,       2'd3, 1'b0, 32'h0,        32'h0,        1'b1});
    tbl.push_back('{1'b0, 32'hFFC,      2'd2, 1'b0, 32'h0,        32'hBEEF0000, 1'b1});
    tbl[19].ef = 1'b0; tbl[19].er = {16'hBEEF, dut.mem[12'hFFD], dut.mem[12'hFFC]};

    foreach (tbl[i]) begin
      if (i == 19) tbl[i].er = {16'hBEEF, dut.mem[12'hFFD], dut.mem[12'hFFC]};
      do_req(tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].sx, tbl[i].wdt, rd, f, lat, ok);
      chk($sformatf("vec%0d_done", i),    32'(ok),  32'd1);
      chk($sformatf("vec%0d_rdata", i),   rd,       tbl[i].er);
      chk($sformatf("vec%0d_fault", i),   32'(f),   32'(tbl[i].ef));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end
    chk("misaligned_mem21", 32'(dut.mem[12'h21]), 32'h33);
    chk("misaligned_mem22", 32'(dut.mem[12'h22]), 32'h22);

    // Backpressure: response held for 5 cycles with resp_ready low.
    @(negedge clock);
    drive(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    g = 0;
    while (!resp_valid && g < 20) begin @(negedge clock); g++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata",      resp_rdata,      32'hDEADBEEF);
      chk("bp_req_ready",  32'(req_ready),  32'd0);
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_valid", 32'(resp_valid), 32'd0);
    chk("bp_release_ready", 32'(req_ready),  32'd1);

    // Reset while the response is pending discards it.
    drive(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    g = 0;
    while (!resp_valid && g < 20) begin @(negedge clock); g++; end
    chk("rresp_pending", 32'(resp_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rresp_valid", 32'(resp_valid), 32'd0);
    chk("rresp_rdata", resp_rdata,      32'h0);
    chk("rresp_ready", 32'(req_ready),  32'd1);
    @(negedge clock);
    reset_n = 1'b1; resp_ready = 1'b1;

    // Reset during WAIT aborts the store.
    do_req(1'b1, 32'h40, 2'd2, 1'b0, 32'hA5A5A5A5, rd, f, lat, ok);
    @(negedge clock);
    drive(1'b1, 32'h40, 2'd2, 1'b0, 32'h12345678);
    req_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rwait_valid", 32'(resp_valid), 32'd0);
    chk("rwait_ready", 32'(req_ready),  32'd1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rwait_mem40", mword(12'h40), 32'hA5A5A5A5);
    chk("rwait_ready_after", 32'(req_ready), 32'd1);

    // Back-to-back with req_valid held high across three requests.
    exp3[0] = 32'hDEADBEEF; exp3[1] = 32'h00000080; exp3[2] = 32'hFFFF8001;
    drive(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    req_valid = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clock);
        g = 1;
        while (!req_ready && g < 20) begin @(negedge clock); g++; end
        chk($sformatf("b2b_gap%0d", i), 32'(g), 32'd1);
      end
      @(negedge clock);
      if (i == 0) drive(1'b0, 32'h20, 2'd0, 1'b0, 32'h0);
      else if (i == 1) drive(1'b0, 32'h24, 2'd1, 1'b1, 32'h0);
      else req_valid = 1'b0;
      g = 1;
      while (!resp_valid && g < 20) begin @(negedge clock); g++; end
      chk($sformatf("b2b_valid%0d", i), 32'(resp_valid), 32'd1);
      chk($sformatf("b2b_rdata%0d", i), resp_rdata, exp3[i]);
    end
    @(negedge clock);
    chk("b2b_no_extra_a", 32'(resp_valid), 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("b2b_no_extra_b", 32'(resp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
